// File: rtl/alu_pkg.sv
// Shared ALU encodings and FSM states; the op codes match the ALU control decoder.
package alu_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW   = 5;

  typedef enum logic [3:0] {
    OP_AND    = 4'b0000,
    OP_OR     = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SLL    = 4'b0011,
    OP_SUB    = 4'b0110,
    OP_PASS_B = 4'b1000
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/alu_shift_iter.sv
// Bit-serial left shifter: loads on start, shifts once per cycle, done when the count is spent.
module alu_shift_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);
  logic [SHW-1:0] cnt;

  // done is raised for one cycle after the last shift, while q holds the final value
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= shamt;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start)
      q <= a;
    else if (busy && (cnt != '0))
      q <= q << 1;
  end
endmodule

// File: rtl/alu_exec.sv
// Handshaked ALU execute stage with registered result/zero/illegal.
// Define ALU_ITER_SHIFT_EN to build SLL as a one-bit-per-cycle shifter instead of a barrel shift.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  state_t           state;
  logic [WIDTH-1:0] res_p1;
  logic             zero_p1;
  logic             ill_p1;
  logic [WIDTH-1:0] calc_res;
  logic             calc_ill;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             sh_start;
  logic             sh_busy;
  logic             sh_done;
  logic [WIDTH-1:0] sh_q;

  assign shamt     = b[SHW-1:0];
  assign in_ready  = !reset && !sh_busy &&
                     ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_HOLD);
  assign result    = res_p1;
  assign zero      = zero_p1;
  assign illegal   = ill_p1;

  always_comb begin
    calc_res = '0;
    calc_ill = 1'b0;
    case (op)
      OP_AND:    calc_res = a & b;
      OP_OR:     calc_res = a | b;
      OP_ADD:    calc_res = a + b;
      OP_SLL:    calc_res = a << shamt;
      OP_SUB:    calc_res = a - b;
      OP_PASS_B: calc_res = b;
      default:   calc_ill = 1'b1;
    endcase
  end

`ifdef ALU_ITER_SHIFT_EN
  // A zero shift amount takes the single-cycle path through calc_res
  assign sh_start = accept && (op == OP_SLL) && (shamt != '0);

  alu_shift_iter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .start(sh_start),
    .a    (a),
    .shamt(shamt),
    .busy (sh_busy),
    .done (sh_done),
    .q    (sh_q)
  );
`else
  assign sh_start = 1'b0;
  assign sh_busy  = 1'b0;
  assign sh_done  = 1'b0;
  assign sh_q     = '0;
`endif

  // Stage p1: result registers, loaded on acceptance or at shifter completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      res_p1  <= '0;
      zero_p1 <= 1'b1;
      ill_p1  <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          if (sh_done) begin
            res_p1  <= sh_q;
            zero_p1 <= (sh_q == '0);
            ill_p1  <= 1'b0;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        if (sh_start) begin
          state <= S_SHIFT;
        end else begin
          res_p1  <= calc_res;
          zero_p1 <= (calc_res == '0);
          ill_p1  <= calc_ill;
          state   <= S_HOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: vector table, scoreboard queue and handshake/reset sequences.
module tb_alu_exec;
`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[14];

  alu_exec #(.WIDTH(32), .SHW(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] o, input logic [31:0] bb);
    return (ITER && o == 4'h3 && bb[4:0] != 5'd0) ? int'(bb[4:0]) + 1 : 1;
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.ill = 1'b0;
    case (o)
      4'h0:    e.res = x & y;
      4'h1:    e.res = x | y;
      4'h2:    e.res = x + y;
      4'h3:    e.res = x << y[4:0];
      4'h6:    e.res = x - y;
      4'h8:    e.res = y;
      default: begin e.res = 32'h0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // Scoreboard: every transfer on the output side pops one expected record
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {31'b0, out_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_zero", {31'b0, zero}, {31'b0, e.z});
        chk("sb_illegal", {31'b0, illegal}, {31'b0, e.ill});
      end
    end
  end

  // Presents a request, waits for acceptance, then scrambles the operand bus
  task automatic issue(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input exp_t e, input bit push);
    int n = 0;
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_out(input int req_lat, input string nm);
    int lat = 1;
    bit ir_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, req_lat);
    chk({nm, "_in_ready_busy"}, {31'b0, ir_bad}, 32'h0);
  endtask

  initial begin
    exp_t e;
    logic [3:0] ops [7];
    tbl[0]  = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tbl[1]  = '{4'h6, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[2]  = '{4'h6, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0};
    tbl[3]  = '{4'h0, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0, 1'b0};
    tbl[4]  = '{4'h1, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 1'b0, 1'b0};
    tbl[5]  = '{4'h2, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0};
    tbl[6]  = '{4'h5, 32'h00000007, 32'h00000009, 32'h00000000, 1'b1, 1'b1};
    tbl[7]  = '{4'h8, 32'h00012345, 32'hABCD0000, 32'hABCD0000, 1'b0, 1'b0};
    tbl[8]  = '{4'h3, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0};
    tbl[9]  = '{4'h3, 32'h00000003, 32'h00000000, 32'h00000003, 1'b0, 1'b0};
    tbl[10] = '{4'h3, 32'hFFFFFFFF, 32'h00000024, 32'hFFFFFFF0, 1'b0, 1'b0};
    tbl[11] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1};
    tbl[12] = '{4'h0, 32'hAAAA5555, 32'h5555AAAA, 32'h00000000, 1'b1, 1'b0};
    tbl[13] = '{4'h3, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0};
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h8, 4'hB};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'h0; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h1);
    chk("rst_illegal", {31'b0, illegal}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // Back-to-back table vectors with the consumer always ready
    for (int i = 0; i < 14; i++) begin
      e = '{tbl[i].res, tbl[i].z, tbl[i].ill};
      issue(tbl[i].op, tbl[i].a, tbl[i].b, e, 1'b1);
      wait_out(exp_lat(tbl[i].op, tbl[i].b), $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = ops[$urandom_range(0, 6)];
      ra = $urandom;
      rb = $urandom;
      issue(ro, ra, rb, model(ro, ra, rb), 1'b1);
      wait_out(exp_lat(ro, rb), $sformatf("rnd%0d", i));
    end

    // Backpressure: result held, second request taken the cycle out_ready rises
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'h2, 32'd2, 32'd3, '{32'd5, 1'b0, 1'b0}, 1'b1);
    wait_out(1, "bp_add");
    op = 4'h8; a = 32'h0; b = 32'h00000077; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_result%0d", i), result, 32'd5);
      chk($sformatf("bp_hold_valid%0d", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("bp_hold_in_ready%0d", i), {31'b0, in_ready}, 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    sb.push_back('{32'h00000077, 1'b0, 1'b0});
    #1;
    in_valid = 1'b0;
    chk("bp_second_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_second_result", result, 32'h00000077);
    @(posedge clk); #1;

    // Reset three cycles into a 10-bit shift discards it
    issue(4'h3, 32'h1, 32'd10, '{32'h00000400, 1'b0, 1'b0}, !ITER);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_zero", {31'b0, zero}, 32'h1);
    chk("mid_rst_illegal", {31'b0, illegal}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_release_in_ready", {31'b0, in_ready}, 32'h1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("mid_rst_no_out_valid", {31'b0, seen}, 32'h0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SHW, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on op/a/b.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 op  input  4  operation code (0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0110 SUB, 1000 PASS_B).
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for SLL.
REQ-010 out_valid  output  1  result registers hold an unconsumed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered, high when result == 0.
REQ-014 illegal  output  1  registered, high when the accepted op was not a listed code.

Function
REQ-015 Transfers occur only when valid && ready on the same edge; in_ready and out_valid are independent of in_valid and out_ready in the same cycle.
REQ-016 States: IDLE, SHIFT, HOLD; IDLE -> HOLD on accepting a non-SLL op, IDLE -> SHIFT on accepting SLL with shift amount != 0, IDLE -> HOLD on SLL with shift amount 0, SHIFT -> HOLD when the remaining count reaches 0, HOLD -> IDLE when out_ready.
REQ-017 in_ready is high only in IDLE, or in HOLD with out_ready high (back-to-back acceptance in the same cycle the result leaves).
REQ-018 Single-cycle ops present out_valid on the edge following acceptance (latency 1).
REQ-019 ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
REQ-020 PASS_B yields b unchanged; AND/OR are bitwise.
REQ-021 An unlisted op yields result 0, zero 1, illegal 1, latency 1; it never hangs.
REQ-022 result, zero and illegal remain stable while out_valid && !out_ready.
REQ-023 Operands are captured at acceptance; later changes on a, b or op have no effect on the operation in flight.
REQ-024 zero and illegal update together with result; illegal clears on the next legal result.

Reset
REQ-025 During reset the state becomes IDLE, out_valid is 0, result is 0, zero is 1, illegal is 0, and the shift counter is 0.
REQ-026 When reset is asserted mid-SHIFT or in HOLD, the operation in flight is discarded and no out_valid is produced for it.
REQ-027 While reset is high, in_ready is 0.

Configuration
REQ-028 Macro ALU_ITER_SHIFT_EN selects the SLL implementation.
REQ-029 With ALU_ITER_SHIFT_EN defined, SLL shifts one bit per cycle in SHIFT, giving latency shamt+1 (shamt 0 gives latency 1).
REQ-030 Without ALU_ITER_SHIFT_EN, SLL is computed in one cycle with latency 1, and the SHIFT state is unreachable.
REQ-031 Results are identical in both builds; only the latency differs.

Structure
REQ-032 Package alu_pkg holds the op encodings (enum alu_op_t), the state enum, and the default WIDTH/SHW constants; the same encodings are used by the existing ALU control decoder.
REQ-033 One sub-module, alu_shift_iter, holds the shift register and down-counter (start, shamt, busy, done); it is instantiated only when ALU_ITER_SHIFT_EN is defined.
REQ-034 Target size is 120-400 lines of RTL in total.

Verification
REQ-035 ADD with a=0xFFFFFFFF and b=1, out_ready held 1: result 0x00000000, zero 1, out_valid exactly 1 cycle after acceptance.
REQ-036 SUB with a=5 and b=7: result 0xFFFFFFFE, zero 0; op=0110 with a=b=0x1234: result 0, zero 1.
REQ-037 SLL with a=0x1 and b=31, iterative build: out_valid 32 cycles after acceptance, result 0x80000000, in_ready low throughout; non-iterative build: same result after 1 cycle.
REQ-038 Backpressure: ADD 2+3 accepted with out_ready=0 for 5 cycles: result is held at 5, in_ready stays 0, and a second request is accepted in the same cycle out_ready rises.
REQ-039 op=0101 with a=7 and b=9: result 0, illegal 1, latency 1; a following PASS_B with b=0xABCD0000 gives illegal 0 and result 0xABCD0000.
REQ-040 reset pulsed 3 cycles into SLL with shamt 10: no out_valid is produced, the outputs take their reset values, and in_ready returns 1 the cycle after reset deasserts.
